// File: rtl/pool2x2_stream_if.sv
// Pixel stream bundle for pool2x2_stream: input pixel side and pooled output side.
// POOL_SOF_SYNC_EN adds the sof input and the sync_err output.
interface pool2x2_stream_if #(
  parameter int DATA_W = 8
);
  logic              din_valid;
  logic [DATA_W-1:0] din;
  logic              dout_valid;
  logic [DATA_W-1:0] dout;
  logic              dout_last;
`ifdef POOL_SOF_SYNC_EN
  logic              sof;
  logic              sync_err;

  modport master (
    output din_valid, din, sof,
    input  dout_valid, dout, dout_last, sync_err
  );
  modport slave (
    input  din_valid, din, sof,
    output dout_valid, dout, dout_last, sync_err
  );
`else
  modport master (
    output din_valid, din,
    input  dout_valid, dout, dout_last
  );
  modport slave (
    input  din_valid, din,
    output dout_valid, dout, dout_last
  );
`endif
endinterface

// File: rtl/pool2x2_stream.sv
// 2x2 stride-2 max/average pooling over a raster-order pixel stream.
// POOL_SOF_SYNC_EN enables sof-based frame resynchronisation with a sync_err pulse.
module pool2x2_stream #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int MODE   = 0
) (
  input logic             clk,
  input logic             rst_n,
  pool2x2_stream_if.slave st
);

  localparam int HW = (MODE == 1) ? DATA_W + 1 : DATA_W;
  localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;
  localparam int LW = IMG_W / 2;
  localparam int AW = (LW > 1) ? $clog2(LW) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  if ((IMG_W % 2) != 0 || IMG_W < 2) begin : g_bad_img_w
    $error("pool2x2_stream: IMG_W must be even and >= 2");
  end
  if ((IMG_H % 2) != 0 || IMG_H < 2) begin : g_bad_img_h
    $error("pool2x2_stream: IMG_H must be even and >= 2");
  end
  if (MODE != 0 && MODE != 1) begin : g_bad_mode
    $error("pool2x2_stream: MODE must be 0 (max) or 1 (average)");
  end

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [CW-1:0] acc_col;
  logic [RW-1:0] acc_row;
  logic [AW-1:0] acc_idx;

  // Effective position of the pixel on din; a sof pixel is forced to (0,0).
  always_comb begin
    acc_col = col;
    acc_row = row;
`ifdef POOL_SOF_SYNC_EN
    if (st.sof) begin
      acc_col = '0;
      acc_row = '0;
    end
`endif
  end

  if (IMG_W == 2) begin : g_idx_single
    assign acc_idx = '0;
  end else begin : g_idx_multi
    assign acc_idx = acc_col[CW-1:1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (st.din_valid) begin
      if (acc_col == COL_LAST) begin
        col <= '0;
        row <= (acc_row == ROW_LAST) ? '0 : acc_row + 1'b1;
      end else begin
        col <= acc_col + 1'b1;
        row <= acc_row;
      end
    end
  end

`ifdef POOL_SOF_SYNC_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st.sync_err <= 1'b0;
    end else begin
      st.sync_err <= st.din_valid && st.sof && ((col != '0) || (row != '0));
    end
  end
`endif

  // Input capture: the accepting edge registers pixel and position together.
  logic              in_valid;
  logic [DATA_W-1:0] in_pix;
  logic              in_col_odd;
  logic              in_row_odd;
  logic              in_last;
  logic [AW-1:0]     in_idx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_valid <= 1'b0;
    end else begin
      in_valid <= st.din_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (st.din_valid) begin
      in_pix     <= st.din;
      in_col_odd <= acc_col[0];
      in_row_odd <= acc_row[0];
      in_last    <= (acc_col == COL_LAST) && (acc_row == ROW_LAST);
      in_idx     <= acc_idx;
    end
  end

  logic [DATA_W-1:0] h0;
  logic [HW-1:0]     h_cur;
  logic [HW-1:0]     lbuf [LW];

  always_ff @(posedge clk) begin
    if (in_valid && !in_col_odd) begin
      h0 <= in_pix;
    end
  end

  if (MODE == 1) begin : g_h_avg
    assign h_cur = {1'b0, h0} + {1'b0, in_pix};
  end else begin : g_h_max
    assign h_cur = (in_pix > h0) ? in_pix : h0;
  end

  always_ff @(posedge clk) begin
    if (in_valid && in_col_odd && !in_row_odd) begin
      lbuf[in_idx] <= h_cur;
    end
  end

  logic          s1_valid;
  logic          s1_last;
  logic [HW-1:0] s1_hc;
  logic [HW-1:0] s1_hb;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= in_valid && in_col_odd && in_row_odd;
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid && in_col_odd && in_row_odd) begin
      s1_hc   <= h_cur;
      s1_hb   <= lbuf[in_idx];
      s1_last <= in_last;
    end
  end

  logic [DATA_W-1:0] v_res;

  if (MODE == 1) begin : g_v_avg
    logic [DATA_W+1:0] v_sum;
    // Four DATA_W values plus the rounding constant fit exactly in DATA_W+2 bits.
    assign v_sum = {1'b0, s1_hb} + {1'b0, s1_hc} + (DATA_W+2)'(2);
    assign v_res = DATA_W'(v_sum >> 2);
  end else begin : g_v_max
    assign v_res = (s1_hc > s1_hb) ? s1_hc : s1_hb;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st.dout_valid <= 1'b0;
      st.dout_last  <= 1'b0;
      st.dout       <= '0;
    end else begin
      st.dout_valid <= s1_valid;
      st.dout_last  <= s1_valid && s1_last;
      if (s1_valid) begin
        st.dout <= v_res;
      end
    end
  end

endmodule

// File: tb/tb_pool2x2_stream.sv
// Directed bench for pool2x2_stream: 4x4 frames on a max-mode and an average-mode instance.
// Define POOL_SOF_SYNC_EN to also exercise sof resynchronisation.
module tb_pool2x2_stream;

  typedef logic [7:0] px16_t [16];
  typedef logic [7:0] r4_t [4];
  typedef struct {
    int         due;
    logic [7:0] emx;
    logic [7:0] eav;
    logic       last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;
  int   ncyc  = 0;
  exp_t pend[$];

  always #5 clk = ~clk;

  pool2x2_stream_if #(.DATA_W(8)) if0 ();
  pool2x2_stream_if #(.DATA_W(8)) if1 ();

  pool2x2_stream #(.DATA_W(8), .IMG_W(4), .IMG_H(4), .MODE(0)) dut_max (
    .clk  (clk),
    .rst_n(rst_n),
    .st   (if0.slave)
  );

  pool2x2_stream #(.DATA_W(8), .IMG_W(4), .IMG_H(4), .MODE(1)) dut_avg (
    .clk  (clk),
    .rst_n(rst_n),
    .st   (if1.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, sample after the next posedge, check against due results.
  task automatic cycle(input logic v, input logic [7:0] d, input logic s);
    exp_t e;
    if0.din_valid = v;
    if1.din_valid = v;
    if0.din       = d;
    if1.din       = d;
`ifdef POOL_SOF_SYNC_EN
    if0.sof = s;
    if1.sof = s;
`else
    if (s) $display("[TB] sof ignored without POOL_SOF_SYNC_EN");
`endif
    @(posedge clk);
    @(negedge clk);
    ncyc++;
    if (pend.size() > 0 && pend[0].due == ncyc) begin
      e = pend.pop_front();
      chk("max_valid", 32'(if0.dout_valid), 32'd1);
      chk("max_dout",  32'(if0.dout),       32'(e.emx));
      chk("max_last",  32'(if0.dout_last),  32'(e.last));
      chk("avg_valid", 32'(if1.dout_valid), 32'd1);
      chk("avg_dout",  32'(if1.dout),       32'(e.eav));
      chk("avg_last",  32'(if1.dout_last),  32'(e.last));
    end else begin
      chk("max_idle",  32'(if0.dout_valid), 32'd0);
      chk("avg_idle",  32'(if1.dout_valid), 32'd0);
      chk("max_nlast", 32'(if0.dout_last),  32'd0);
    end
  endtask

  task automatic frame(input px16_t pix, input r4_t emx, input r4_t eav,
                       input logic gap, input logic sof_first, input logic serr,
                       input logic last_ok);
    exp_t e;
    int   k = 0;
    for (int i = 0; i < 16; i++) begin
      if (i == 5 || i == 7 || i == 13 || i == 15) begin
        e.due  = ncyc + 3;
        e.emx  = emx[k];
        e.eav  = eav[k];
        e.last = last_ok && (i == 15);
        pend.push_back(e);
        k++;
      end
      cycle(1'b1, pix[i], sof_first && (i == 0));
`ifdef POOL_SOF_SYNC_EN
      if (i == 0) chk("sync_err_first", 32'(if0.sync_err), 32'(serr));
      if (i == 1) chk("sync_err_clear", 32'(if0.sync_err), 32'd0);
`else
      if (serr && i == 0) $display("[TB] sync_err not built");
`endif
      if (gap) cycle(1'b0, 8'hA5, 1'b0);
    end
  endtask

  task automatic flush(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    px16_t asc, desc, ones, zeros;
    r4_t   mx_asc, av_asc, mx_desc, av_desc, r255, r0;

    for (int i = 0; i < 16; i++) begin
      asc[i]   = 8'(i);
      desc[i]  = 8'(15 - i);
      ones[i]  = 8'd255;
      zeros[i] = 8'd0;
    end
    mx_asc  = '{8'd5,  8'd7,  8'd13, 8'd15};
    av_asc  = '{8'd3,  8'd5,  8'd11, 8'd13};
    mx_desc = '{8'd15, 8'd13, 8'd7,  8'd5};
    av_desc = '{8'd13, 8'd11, 8'd5,  8'd3};
    r255    = '{8'd255, 8'd255, 8'd255, 8'd255};
    r0      = '{8'd0, 8'd0, 8'd0, 8'd0};

    rst_n = 1'b0;
    if0.din_valid = 1'b0;
    if1.din_valid = 1'b0;
    if0.din = '0;
    if1.din = '0;
`ifdef POOL_SOF_SYNC_EN
    if0.sof = 1'b0;
    if1.sof = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(if0.dout_valid), 32'd0);
    chk("rst_dout",  32'(if0.dout),       32'd0);
    chk("rst_last",  32'(if0.dout_last),  32'd0);
    chk("rst_avg",   32'(if1.dout),       32'd0);
`ifdef POOL_SOF_SYNC_EN
    chk("rst_serr",  32'(if0.sync_err),   32'd0);
`endif
    rst_n = 1'b1;

    // Contiguous ascending frame, then saturating and zero frames.
    frame(asc, mx_asc, av_asc, 1'b0, 1'b0, 1'b0, 1'b1);
    flush(4);
    frame(ones, r255, r255, 1'b0, 1'b0, 1'b0, 1'b1);
    frame(zeros, r0, r0, 1'b0, 1'b0, 1'b0, 1'b1);
    flush(4);

    // Alternating din_valid gaps.
    frame(asc, mx_asc, av_asc, 1'b1, 1'b0, 1'b0, 1'b1);
    flush(4);

    // Back-to-back frames.
    frame(asc, mx_asc, av_asc, 1'b0, 1'b0, 1'b0, 1'b1);
    frame(desc, mx_desc, av_desc, 1'b0, 1'b0, 1'b0, 1'b1);
    flush(4);

    // Reset after pixel 6 of a frame discards the pending window.
    for (int i = 0; i <= 6; i++) cycle(1'b1, asc[i], 1'b0);
    rst_n = 1'b0;
    cycle(1'b0, 8'h00, 1'b0);
    rst_n = 1'b1;
    chk("midrst_dout", 32'(if0.dout), 32'd0);
    flush(3);
    frame(asc, mx_asc, av_asc, 1'b0, 1'b0, 1'b0, 1'b1);
    flush(4);

`ifdef POOL_SOF_SYNC_EN
    // Two stray pixels, then sof restarts the frame mid-row.
    cycle(1'b1, 8'd10, 1'b0);
    cycle(1'b1, 8'd20, 1'b0);
    frame(asc, mx_asc, av_asc, 1'b0, 1'b1, 1'b1, 1'b1);
    frame(desc, mx_desc, av_desc, 1'b0, 1'b1, 1'b0, 1'b1);
    flush(4);
`endif

    chk("pending_empty", 32'(pend.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
